sm_free_list: RTL and testbench

Free-pointer allocator directly upstream of shared-memory write path. Holds pool of unused `sm_ptr_t` slot pointers in circular FIFO; on each write-allocation request returns either a pointer with `WR_OK` or `WR_ERR_NO_SPACE`, forming the `sm_res_t` result consumed by the write stage. Pointers released by the `CLEAR` command path return to the pool.

---
 rtl/sm_free_list_if.sv | 27 ++
 rtl/sm_free_list.sv | 177 +++++++++++++++++
 tb/tb_sm_free_list.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_free_list_if.sv
// Allocation/release handshake and pool status between the free-pointer allocator and its users.
interface sm_free_list_if #(
    parameter int unsigned PTR_WIDTH = 8,
    parameter int unsigned NUM_PTRS  = 256
);
    localparam int unsigned CNT_W = $clog2(NUM_PTRS + 1);

    logic                 alloc_req_i;
    logic                 alloc_vld_o;
    logic [31:0]          alloc_code_o;
    logic [PTR_WIDTH-1:0] alloc_ptr_o;
    logic                 free_vld_i;
    logic [PTR_WIDTH-1:0] free_ptr_i;
    logic                 free_err_o;
    logic [CNT_W-1:0]     free_cnt_o;
    logic                 init_done_o;

    modport master (
        output alloc_req_i, free_vld_i, free_ptr_i,
        input  alloc_vld_o, alloc_code_o, alloc_ptr_o, free_err_o, free_cnt_o, init_done_o
    );

    modport slave (
        input  alloc_req_i, free_vld_i, free_ptr_i,
        output alloc_vld_o, alloc_code_o, alloc_ptr_o, free_err_o, free_cnt_o, init_done_o
    );
endinterface

// File: rtl/sm_free_list.sv
// Shared-memory free-pointer allocator: circular FIFO of unused slot pointers.
// Optional SM_FREE_LIST_DOUBLE_FREE_CHECK_EN adds an allocation bitmap rejecting double frees.
package sm;
    localparam int unsigned SM_PTR_WIDTH = 8;

    typedef logic [SM_PTR_WIDTH-1:0] sm_ptr_t;
    typedef logic [31:0]             sm_res_code_t;

    localparam sm_res_code_t WR_OK           = 32'd0;
    localparam sm_res_code_t WR_ERR_NO_SPACE = 32'd1;

    typedef struct packed {
        sm_res_code_t code;
        sm_ptr_t      ptr;
    } sm_res_t;
endpackage

module sm_free_list #(
    parameter int unsigned PTR_WIDTH = sm::SM_PTR_WIDTH,
    parameter int unsigned NUM_PTRS  = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    sm_free_list_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_PTRS);
    localparam int unsigned CNT_W = $clog2(NUM_PTRS + 1);
    localparam int unsigned RNG_W = PTR_WIDTH + 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     init_idx;
    logic [IDX_W-1:0]     rd_ptr;
    logic [IDX_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [PTR_WIDTH-1:0] mem [NUM_PTRS];

    logic                 alloc_vld;
    sm::sm_res_code_t     alloc_code;
    logic [PTR_WIDTH-1:0] alloc_ptr;
    logic                 free_err;
    logic                 init_done;

    logic                 in_range;
    logic                 pool_full;
    logic                 pool_empty;
    logic                 free_ok;
    logic                 pop;
    logic                 push;
    logic [IDX_W-1:0]     free_idx;
    logic                 mem_we;
    logic [IDX_W-1:0]     mem_waddr;
    logic [PTR_WIDTH-1:0] mem_wdata;

`ifdef SM_FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic [NUM_PTRS-1:0]  alloc_map;
`endif

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NUM_PTRS - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    // Release/allocation qualification; the pool is only touched in RUN.
    always_comb begin
        in_range   = ({1'b0, bus.free_ptr_i} < RNG_W'(NUM_PTRS));
        free_idx   = IDX_W'(bus.free_ptr_i);
        pool_full  = (count == CNT_W'(NUM_PTRS));
        pool_empty = (count == '0);
        free_ok    = in_range && !pool_full;
`ifdef SM_FREE_LIST_DOUBLE_FREE_CHECK_EN
        free_ok    = free_ok && alloc_map[free_idx];
`endif
        pop        = (state == ST_RUN) && bus.alloc_req_i && !pool_empty;
        push       = (state == ST_RUN) && bus.free_vld_i && free_ok;
    end

    // Single write port: identity fill during INIT, released pointers during RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr;
        mem_wdata = bus.free_ptr_i;
        if (!rst_i) begin
            if (state == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = init_idx;
                mem_wdata = PTR_WIDTH'(init_idx);
            end else if (push) begin
                mem_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM with registered result and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_INIT;
            init_idx   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            alloc_vld  <= 1'b0;
            alloc_code <= sm::WR_OK;
            alloc_ptr  <= '0;
            free_err   <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            alloc_vld  <= bus.alloc_req_i;
            alloc_code <= sm::WR_OK;
            alloc_ptr  <= '0;
            free_err   <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (bus.alloc_req_i) begin
                        alloc_code <= sm::WR_ERR_NO_SPACE;
                    end
                    free_err <= bus.free_vld_i;
                    init_idx <= init_idx + IDX_W'(1);
                    if (init_idx == IDX_W'(NUM_PTRS - 1)) begin
                        state     <= ST_RUN;
                        init_idx  <= '0;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        count     <= CNT_W'(NUM_PTRS);
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        alloc_ptr <= mem[rd_ptr];
                        rd_ptr    <= wrap_inc(rd_ptr);
                    end else if (bus.alloc_req_i) begin
                        alloc_code <= sm::WR_ERR_NO_SPACE;
                    end
                    if (push) begin
                        wr_ptr <= wrap_inc(wr_ptr);
                    end
                    free_err <= bus.free_vld_i && !free_ok;
                    count    <= count + CNT_W'(push) - CNT_W'(pop);
                end
                default: state <= ST_INIT;
            endcase
        end
    end

`ifdef SM_FREE_LIST_DOUBLE_FREE_CHECK_EN
    // One bit per pointer: set while the pointer is held by a client.
    always_ff @(posedge clk_i) begin
        if (rst_i || state == ST_INIT) begin
            alloc_map <= '0;
        end else begin
            if (push) begin
                alloc_map[free_idx] <= 1'b0;
            end
            if (pop) begin
                alloc_map[IDX_W'(mem[rd_ptr])] <= 1'b1;
            end
        end
    end
`endif

    assign bus.alloc_vld_o  = alloc_vld;
    assign bus.alloc_code_o = alloc_code;
    assign bus.alloc_ptr_o  = alloc_ptr;
    assign bus.free_err_o   = free_err;
    assign bus.free_cnt_o   = count;
    assign bus.init_done_o  = init_done;
endmodule

// File: tb/tb_sm_free_list.sv
// Directed bench for sm_free_list with a 4-entry pool.
module tb_sm_free_list;
    localparam int unsigned PW = 8;
    localparam int unsigned NP = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sm_free_list_if #(.PTR_WIDTH(PW), .NUM_PTRS(NP)) bus ();

    sm_free_list #(.PTR_WIDTH(PW), .NUM_PTRS(NP)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int k = 0;
        while (bus.init_done_o !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        n_tests++;
        if (bus.init_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL init_timeout: init_done=%0b required 1", bus.init_done_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.alloc_req_i = 1'b0;
        bus.free_vld_i  = 1'b0;
        bus.free_ptr_i  = '0;
        step();
        step();
        n_tests++;
        if ({bus.alloc_vld_o, bus.free_err_o, bus.init_done_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: vld/err/done=%b required 000",
                     {bus.alloc_vld_o, bus.free_err_o, bus.init_done_o});
        end
        n_tests++;
        if (bus.alloc_code_o !== sm::WR_OK || bus.alloc_ptr_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_result: code=%0d ptr=%0d required 0 0", bus.alloc_code_o, bus.alloc_ptr_o);
        end
        n_tests++;
        if (bus.free_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d required 0", bus.free_cnt_o);
        end
        rst = 1'b0;
        repeat (3) step();
        n_tests++;
        if (bus.init_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL init_early: init_done=%0b required 0 after 3 cycles", bus.init_done_o);
        end
        step();
        n_tests++;
        if (bus.init_done_o !== 1'b1 || bus.free_cnt_o !== 3'd4) begin
            n_fail++;
            $display("FAIL init_latency: done=%0b cnt=%0d required 1 4", bus.init_done_o, bus.free_cnt_o);
        end
    endtask

    task automatic test_init_requests();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.free_vld_i = 1'b1;
        bus.free_ptr_i = 8'd1;
        step();
        n_tests++;
        if (bus.free_err_o !== 1'b1 || bus.alloc_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL init_free: err=%0b vld=%0b required 1 0", bus.free_err_o, bus.alloc_vld_o);
        end
        bus.free_vld_i  = 1'b0;
        bus.alloc_req_i = 1'b1;
        step();
        n_tests++;
        if (bus.alloc_vld_o !== 1'b1 || bus.alloc_code_o !== sm::WR_ERR_NO_SPACE ||
            bus.alloc_ptr_o !== 8'd0 || bus.free_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL init_alloc: vld=%0b code=%0d ptr=%0d err=%0b required 1 1 0 0",
                     bus.alloc_vld_o, bus.alloc_code_o, bus.alloc_ptr_o, bus.free_err_o);
        end
        bus.alloc_req_i = 1'b0;
        wait_init();
        n_tests++;
        if (bus.free_cnt_o !== 3'd4) begin
            n_fail++;
            $display("FAIL init_cnt: got %0d required 4", bus.free_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        bus.alloc_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (bus.alloc_vld_o !== 1'b1 || bus.alloc_code_o !== sm::WR_OK ||
                bus.alloc_ptr_o !== 8'(i) || bus.free_cnt_o !== 3'(3 - i)) begin
                n_fail++;
                $display("FAIL b2b_alloc%0d: vld=%0b code=%0d ptr=%0d cnt=%0d required 1 0 %0d %0d",
                         i, bus.alloc_vld_o, bus.alloc_code_o, bus.alloc_ptr_o, bus.free_cnt_o, i, 3 - i);
            end
        end
        step();
        n_tests++;
        if (bus.alloc_vld_o !== 1'b1 || bus.alloc_code_o !== sm::WR_ERR_NO_SPACE ||
            bus.alloc_ptr_o !== 8'd0 || bus.free_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_empty: vld=%0b code=%0d ptr=%0d cnt=%0d required 1 1 0 0",
                     bus.alloc_vld_o, bus.alloc_code_o, bus.alloc_ptr_o, bus.free_cnt_o);
        end
        bus.alloc_req_i = 1'b0;
        step();
        n_tests++;
        if (bus.alloc_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: vld=%0b required 0", bus.alloc_vld_o);
        end
    endtask

    task automatic test_fifo_recycle();
        bus.free_vld_i = 1'b1;
        bus.free_ptr_i = 8'd2;
        step();
        n_tests++;
        if (bus.free_cnt_o !== 3'd1 || bus.free_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL recycle_free2: cnt=%0d err=%0b required 1 0", bus.free_cnt_o, bus.free_err_o);
        end
        bus.free_ptr_i = 8'd0;
        step();
        n_tests++;
        if (bus.free_cnt_o !== 3'd2) begin
            n_fail++;
            $display("FAIL recycle_free0: cnt=%0d required 2", bus.free_cnt_o);
        end
        bus.free_vld_i  = 1'b0;
        bus.alloc_req_i = 1'b1;
        step();
        n_tests++;
        if (bus.alloc_ptr_o !== 8'd2 || bus.alloc_code_o !== sm::WR_OK || bus.free_cnt_o !== 3'd1) begin
            n_fail++;
            $display("FAIL recycle_pop1: ptr=%0d code=%0d cnt=%0d required 2 0 1",
                     bus.alloc_ptr_o, bus.alloc_code_o, bus.free_cnt_o);
        end
        step();
        n_tests++;
        if (bus.alloc_ptr_o !== 8'd0 || bus.alloc_code_o !== sm::WR_OK || bus.free_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL recycle_pop2: ptr=%0d code=%0d cnt=%0d required 0 0 0",
                     bus.alloc_ptr_o, bus.alloc_code_o, bus.free_cnt_o);
        end
        bus.alloc_req_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        bus.alloc_req_i = 1'b1;
        bus.free_vld_i  = 1'b1;
        bus.free_ptr_i  = 8'd3;
        step();
        n_tests++;
        if (bus.alloc_code_o !== sm::WR_ERR_NO_SPACE || bus.free_cnt_o !== 3'd1 || bus.free_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_no_bypass: code=%0d cnt=%0d err=%0b required 1 1 0",
                     bus.alloc_code_o, bus.free_cnt_o, bus.free_err_o);
        end
        bus.free_vld_i = 1'b0;
        step();
        n_tests++;
        if (bus.alloc_code_o !== sm::WR_OK || bus.alloc_ptr_o !== 8'd3 || bus.free_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL simul_next: code=%0d ptr=%0d cnt=%0d required 0 3 0",
                     bus.alloc_code_o, bus.alloc_ptr_o, bus.free_cnt_o);
        end
        bus.alloc_req_i = 1'b0;
    endtask

    task automatic test_range();
        bus.free_vld_i = 1'b1;
        bus.free_ptr_i = 8'd7;
        step();
        n_tests++;
        if (bus.free_err_o !== 1'b1 || bus.free_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL range_err: err=%0b cnt=%0d required 1 0", bus.free_err_o, bus.free_cnt_o);
        end
        bus.free_vld_i = 1'b0;
        step();
        n_tests++;
        if (bus.free_err_o !== 1'b0 || bus.free_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL range_pulse: err=%0b cnt=%0d required 0 0", bus.free_err_o, bus.free_cnt_o);
        end
    endtask

    task automatic test_double_free();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init();
`ifdef SM_FREE_LIST_DOUBLE_FREE_CHECK_EN
        bus.alloc_req_i = 1'b1;
        step();
        bus.alloc_req_i = 1'b0;
        bus.free_vld_i  = 1'b1;
        bus.free_ptr_i  = 8'd0;
        step();
        n_tests++;
        if (bus.free_err_o !== 1'b0 || bus.free_cnt_o !== 3'd4) begin
            n_fail++;
            $display("FAIL dbl_first: err=%0b cnt=%0d required 0 4", bus.free_err_o, bus.free_cnt_o);
        end
        step();
        n_tests++;
        if (bus.free_err_o !== 1'b1 || bus.free_cnt_o !== 3'd4) begin
            n_fail++;
            $display("FAIL dbl_second: err=%0b cnt=%0d required 1 4", bus.free_err_o, bus.free_cnt_o);
        end
        bus.free_vld_i  = 1'b0;
        bus.alloc_req_i = 1'b1;
        step();
        bus.alloc_req_i = 1'b0;
        bus.free_vld_i  = 1'b1;
        bus.free_ptr_i  = 8'd2;
        step();
        n_tests++;
        if (bus.free_err_o !== 1'b1 || bus.free_cnt_o !== 3'd3) begin
            n_fail++;
            $display("FAIL dbl_never_alloc: err=%0b cnt=%0d required 1 3", bus.free_err_o, bus.free_cnt_o);
        end
`else
        bus.free_vld_i = 1'b1;
        bus.free_ptr_i = 8'd1;
        step();
        n_tests++;
        if (bus.free_err_o !== 1'b1 || bus.free_cnt_o !== 3'd4) begin
            n_fail++;
            $display("FAIL full_free: err=%0b cnt=%0d required 1 4", bus.free_err_o, bus.free_cnt_o);
        end
        bus.free_vld_i  = 1'b0;
        bus.alloc_req_i = 1'b1;
        step();
        step();
        bus.alloc_req_i = 1'b0;
        bus.free_vld_i  = 1'b1;
        bus.free_ptr_i  = 8'd0;
        step();
        step();
        n_tests++;
        if (bus.free_err_o !== 1'b0 || bus.free_cnt_o !== 3'd4) begin
            n_fail++;
            $display("FAIL dup_accepted: err=%0b cnt=%0d required 0 4", bus.free_err_o, bus.free_cnt_o);
        end
`endif
        bus.free_vld_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init();
        bus.alloc_req_i = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        n_tests++;
        if ({bus.alloc_vld_o, bus.free_err_o, bus.init_done_o} !== 3'b000 ||
            bus.alloc_code_o !== sm::WR_OK || bus.alloc_ptr_o !== 8'd0 || bus.free_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_vals: vld/err/done=%b code=%0d ptr=%0d cnt=%0d required 000 0 0 0",
                     {bus.alloc_vld_o, bus.free_err_o, bus.init_done_o},
                     bus.alloc_code_o, bus.alloc_ptr_o, bus.free_cnt_o);
        end
        rst = 1'b0;
        bus.alloc_req_i = 1'b0;
        repeat (4) step();
        n_tests++;
        if (bus.init_done_o !== 1'b1 || bus.free_cnt_o !== 3'd4) begin
            n_fail++;
            $display("FAIL midreset_init: done=%0b cnt=%0d required 1 4", bus.init_done_o, bus.free_cnt_o);
        end
        bus.alloc_req_i = 1'b1;
        step();
        bus.alloc_req_i = 1'b0;
        n_tests++;
        if (bus.alloc_code_o !== sm::WR_OK || bus.alloc_ptr_o !== 8'd0 || bus.free_cnt_o !== 3'd3) begin
            n_fail++;
            $display("FAIL midreset_alloc: code=%0d ptr=%0d cnt=%0d required 0 0 3",
                     bus.alloc_code_o, bus.alloc_ptr_o, bus.free_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_init_requests();
        test_back_to_back();
        test_fifo_recycle();
        test_simultaneous();
        test_range();
        test_double_free();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
